freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 12 +
 rtl/sync_edge_det.sv | 37 +++
 rtl/freq_meter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the freq_meter block (optional high-time
// measurement is enabled by defining FREQ_METER_HIGH_TIME_EN).
package freq_meter_pkg;

    localparam int unsigned CNT_W_DEF = 24;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge detector for an
// asynchronous input; the level tap exists only with FREQ_METER_HIGH_TIME_EN.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
`ifdef FREQ_METER_HIGH_TIME_EN
    ,
    output logic level
`endif
);

    logic s1;
    logic s2;
    logic s3;

    // s3 is aligned with rise, so level is already high in the rise cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

`ifdef FREQ_METER_HIGH_TIME_EN
    assign level = s3;
`endif

endmodule

// File: rtl/freq_meter.sv
// Period meter for an asynchronous divided clock with lock and loss-of-signal
// detection. Define FREQ_METER_HIGH_TIME_EN to add the high_time output.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned EXPECTED   = 2000,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 4 * EXPECTED
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             timeout
`ifdef FREQ_METER_HIGH_TIME_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]        CNT_MAX = '1;
    localparam logic [CNT_W-1:0]        TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]           LOCK_N  = MW'(LOCK_COUNT);
    localparam logic signed [CNT_W:0]   EXP_S   = (CNT_W + 1)'(EXPECTED);
    localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W + 1)'(TOL);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  period_nxt;
    logic              valid_nxt;
    logic              locked_nxt;
    logic              timeout_nxt;
    logic [MW-1:0]     match;
    logic [MW-1:0]     match_nxt;
    logic [MW-1:0]     match_inc;
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] adiff;
    logic              in_tol;
    logic              rise;

`ifdef FREQ_METER_HIGH_TIME_EN
    logic              level;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  hi_cnt_nxt;
    logic [CNT_W-1:0]  high_time_nxt;
`endif

    sync_edge_det u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sig_in),
        .rise    (rise)
`ifdef FREQ_METER_HIGH_TIME_EN
        ,
        .level   (level)
`endif
    );

    // cnt_inc doubles as the period candidate: cnt+1, pinned at full scale
    always_comb begin
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        match_inc = (match == LOCK_N) ? match : match + 1'b1;
        diff      = $signed({1'b0, cnt_inc}) - EXP_S;
        adiff     = diff[CNT_W] ? -diff : diff;
        in_tol    = (adiff <= TOL_S);
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period;
        valid_nxt   = 1'b0;
        locked_nxt  = locked;
        timeout_nxt = timeout;
        match_nxt   = match;

        if (!en) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            match_nxt  = '0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (rise) begin
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    // an edge on the timeout cycle still completes the measurement
                    if (rise) begin
                        period_nxt  = cnt_inc;
                        valid_nxt   = 1'b1;
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b0;
                        if (in_tol) begin
                            match_nxt  = match_inc;
                            locked_nxt = (match_inc == LOCK_N);
                        end else begin
                            match_nxt  = '0;
                            locked_nxt = 1'b0;
                        end
                    end else if (cnt == TO_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b1;
                        locked_nxt  = 1'b0;
                        match_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
            match   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            period  <= period_nxt;
            valid   <= valid_nxt;
            locked  <= locked_nxt;
            timeout <= timeout_nxt;
            match   <= match_nxt;
        end
    end

`ifdef FREQ_METER_HIGH_TIME_EN
    // restarting at 1 on rise counts the rise cycle itself as high
    always_comb begin
        hi_cnt_nxt    = hi_cnt;
        high_time_nxt = high_time;
        if (rise) begin
            hi_cnt_nxt = CNT_W'(1);
        end else if (level && (hi_cnt != CNT_MAX)) begin
            hi_cnt_nxt = hi_cnt + 1'b1;
        end
        if (valid_nxt) begin
            high_time_nxt = hi_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt    <= '0;
            high_time <= '0;
        end else begin
            hi_cnt    <= hi_cnt_nxt;
            high_time <= high_time_nxt;
        end
    end
`endif

endmodule
